// File: rtl/tap_seq_mux.sv
// Time-multiplexed channel sequencer: snapshots NUM_CH packed words on start and
// streams them one per accepted beat, ascending or descending, to a serial MAC.
module tap_seq_mux #(
  parameter int WIDTH  = 18,
  parameter int NUM_CH = 21,
  localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic                    dir_i,
  input  logic [NUM_CH*WIDTH-1:0] data_i,
  input  logic                    ready_i,
  output logic [WIDTH-1:0]        data_o,
  output logic [SEL_W-1:0]        sel_o,
  output logic                    valid_o,
  output logic                    last_o,
  output logic                    busy_o,
  output logic                    done_o
);

  localparam logic [SEL_W-1:0] SEL_MAX  = SEL_W'(NUM_CH - 1);
  localparam logic [SEL_W-1:0] SEL_ZERO = {SEL_W{1'b0}};

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e                    state_q, state_d;
  logic [NUM_CH*WIDTH-1:0]   snap_q, snap_d;
  logic [SEL_W-1:0]          sel_q, sel_d;
  logic                      dir_q, dir_d;
  logic                      done_q, done_d;
  logic                      run_s;
  logic                      last_s;
  logic [WIDTH-1:0]          data_sel_s;

  assign run_s  = (state_q == ST_RUN);
  assign last_s = run_s && (dir_q ? (sel_q == SEL_ZERO) : (sel_q == SEL_MAX));

  // One-hot AND-OR read of the snapshot keeps the index width-safe for any NUM_CH
  always_comb begin
    data_sel_s = {WIDTH{1'b0}};
    for (int k = 0; k < NUM_CH; k++) begin
      data_sel_s = data_sel_s |
                   ({WIDTH{sel_q == SEL_W'(k)}} & snap_q[k*WIDTH +: WIDTH]);
    end
  end

  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    sel_d   = sel_q;
    dir_d   = dir_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_RUN;
          snap_d  = data_i;
          dir_d   = dir_i;
          sel_d   = dir_i ? SEL_MAX : SEL_ZERO;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (ready_i) begin
          if (last_s) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else if (dir_q) begin
            sel_d = sel_q - SEL_W'(1);
          end else begin
            sel_d = sel_q + SEL_W'(1);
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      snap_q  <= {(NUM_CH*WIDTH){1'b0}};
      sel_q   <= SEL_ZERO;
      dir_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      sel_q   <= sel_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
    end
  end

  assign data_o  = data_sel_s;
  assign sel_o   = sel_q;
  assign valid_o = run_s;
  assign busy_o  = run_s;
  assign last_o  = last_s;
  assign done_o  = done_q;

endmodule

// File: tb/tb_tap_seq_mux.sv
// Directed bench for tap_seq_mux: 21-channel main instance plus 1- and 2-channel
// degenerate instances sharing clock and reset.
module tb_tap_seq_mux;

  localparam int W = 18;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // 21-channel instance
  logic            start, dir, ready;
  logic [21*W-1:0] din;
  logic [W-1:0]    dout;
  logic [4:0]      sel;
  logic            valid, last, busy, done;

  tap_seq_mux #(.WIDTH(W), .NUM_CH(21)) u21 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .dir_i(dir), .data_i(din),
    .ready_i(ready), .data_o(dout), .sel_o(sel), .valid_o(valid),
    .last_o(last), .busy_o(busy), .done_o(done)
  );

  // 2-channel instance
  logic            start2, dir2;
  logic [2*W-1:0]  din2;
  logic [W-1:0]    dout2;
  logic [0:0]      sel2;
  logic            valid2, last2, busy2, done2;

  tap_seq_mux #(.WIDTH(W), .NUM_CH(2)) u2 (
    .clk_i(clk), .rst_i(rst), .start_i(start2), .dir_i(dir2), .data_i(din2),
    .ready_i(1'b1), .data_o(dout2), .sel_o(sel2), .valid_o(valid2),
    .last_o(last2), .busy_o(busy2), .done_o(done2)
  );

  // 1-channel instance
  logic            start1, dir1;
  logic [W-1:0]    din1;
  logic [W-1:0]    dout1;
  logic [0:0]      sel1;
  logic            valid1, last1, busy1, done1;

  tap_seq_mux #(.WIDTH(W), .NUM_CH(1)) u1 (
    .clk_i(clk), .rst_i(rst), .start_i(start1), .dir_i(dir1), .data_i(din1),
    .ready_i(1'b1), .data_o(dout1), .sel_o(sel1), .valid_o(valid1),
    .last_o(last1), .busy_o(busy1), .done_o(done1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_ramp();
    for (int k = 0; k < 21; k++) din[k*W +: W] = W'(32'h100 + k);
  endtask

  // Expects the first ascending beat to be visible; ends in the cycle after the last beat
  task automatic sweep_asc(input string tag);
    for (int i = 0; i < 21; i++) begin
      chk({tag, "_valid"}, 32'(valid), 32'd1);
      chk({tag, "_sel"},   32'(sel),   32'(i));
      chk({tag, "_data"},  32'(dout),  32'h100 + 32'(i));
      chk({tag, "_last"},  32'(last),  32'(i == 20));
      chk({tag, "_done"},  32'(done),  32'd0);
      step();
    end
    chk({tag, "_end_done"},  32'(done),  32'd1);
    chk({tag, "_end_valid"}, 32'(valid), 32'd0);
    chk({tag, "_end_busy"},  32'(busy),  32'd0);
  endtask

  int exp_sel;
  int xfers;
  bit finished;

  initial begin
    start = 1'b0; dir = 1'b0; ready = 1'b1; din = '0;
    start2 = 1'b0; dir2 = 1'b0; din2 = '0;
    start1 = 1'b0; dir1 = 1'b0; din1 = '0;

    // Reset state
    #2;
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_sel",   32'(sel),   32'd0);
    chk("rst_data",  32'(dout),  32'd0);
    chk("rst_last",  32'(last),  32'd0);
    chk("rst_busy",  32'(busy),  32'd0);
    chk("rst_done",  32'(done),  32'd0);
    chk("rst_valid2", 32'(valid2), 32'd0);
    chk("rst_valid1", 32'(valid1), 32'd0);
    #10 rst = 1'b0;
    step();

    // Ascending, no stall
    load_ramp();
    dir = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    sweep_asc("asc");
    step();
    chk("asc_done_pulse", 32'(done), 32'd0);

    // Descending with backpressure in cycles 3..5
    dir = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    exp_sel = 20; xfers = 0; finished = 1'b0;
    for (int c = 1; c < 40 && !finished; c++) begin
      ready = !(c >= 3 && c <= 5);
      chk("dsc_valid", 32'(valid), 32'd1);
      chk("dsc_sel",   32'(sel),   32'(exp_sel));
      chk("dsc_data",  32'(dout),  32'h100 + 32'(exp_sel));
      chk("dsc_last",  32'(last),  32'(exp_sel == 0));
      if (ready) begin
        xfers++;
        if (exp_sel == 0) finished = 1'b1;
        else exp_sel--;
      end
      step();
    end
    ready = 1'b1;
    chk("dsc_finished", 32'(finished), 32'd1);
    chk("dsc_xfers", 32'(xfers), 32'd21);
    chk("dsc_done",  32'(done),  32'd1);
    step();

    // Snapshot isolation and start ignored during RUN
    load_ramp();
    dir = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    exp_sel = 0; finished = 1'b0;
    for (int c = 1; c < 40 && !finished; c++) begin
      chk("iso_valid", 32'(valid), 32'd1);
      chk("iso_sel",   32'(sel),   32'(exp_sel));
      chk("iso_data",  32'(dout),  32'h100 + 32'(exp_sel));
      if (c >= 1) din = {(21*W){1'b1}};
      start = (c == 5 || c == 10);
      if (exp_sel == 20) finished = 1'b1;
      else exp_sel++;
      step();
    end
    start = 1'b0;
    chk("iso_finished", 32'(finished), 32'd1);
    chk("iso_done", 32'(done), 32'd1);
    step();
    chk("iso_no_restart", 32'(valid), 32'd0);
    chk("iso_single_done", 32'(done), 32'd0);

    // Back-to-back: start in the done cycle
    load_ramp();
    start = 1'b1;
    step();
    start = 1'b0;
    sweep_asc("b2b_a");
    start = 1'b1;
    step();
    start = 1'b0;
    chk("b2b_restart_done", 32'(done), 32'd0);
    sweep_asc("b2b_b");
    step();

    // Reset mid-sweep, asserted between edges
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 8; i++) step();
    chk("mid_sel_before", 32'(sel), 32'd8);
    #2 rst = 1'b1;
    #1;
    chk("mid_valid", 32'(valid), 32'd0);
    chk("mid_sel",   32'(sel),   32'd0);
    chk("mid_data",  32'(dout),  32'd0);
    chk("mid_last",  32'(last),  32'd0);
    chk("mid_busy",  32'(busy),  32'd0);
    chk("mid_done",  32'(done),  32'd0);
    step();
    #3 rst = 1'b0;
    step();
    chk("mid_no_done", 32'(done), 32'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    sweep_asc("post_rst");
    step();

    // NUM_CH = 1, both directions
    din1 = 18'h0002A;
    for (int d = 0; d < 2; d++) begin
      dir1 = d[0]; start1 = 1'b1;
      step();
      start1 = 1'b0;
      chk("n1_valid", 32'(valid1), 32'd1);
      chk("n1_sel",   32'(sel1),   32'd0);
      chk("n1_last",  32'(last1),  32'd1);
      chk("n1_data",  32'(dout1),  32'h2A);
      step();
      chk("n1_done",  32'(done1),  32'd1);
      chk("n1_idle",  32'(valid1), 32'd0);
      step();
    end

    // NUM_CH = 2, both directions
    din2 = {18'h000A1, 18'h000A0};
    for (int d = 0; d < 2; d++) begin
      dir2 = d[0]; start2 = 1'b1;
      step();
      start2 = 1'b0;
      for (int b = 0; b < 2; b++) begin
        exp_sel = (d == 0) ? b : 1 - b;
        chk("n2_valid", 32'(valid2), 32'd1);
        chk("n2_sel",   32'(sel2),   32'(exp_sel));
        chk("n2_data",  32'(dout2),  32'hA0 + 32'(exp_sel));
        chk("n2_last",  32'(last2),  32'(b == 1));
        chk("n2_nodone", 32'(done2), 32'd0);
        step();
      end
      chk("n2_done", 32'(done2),  32'd1);
      chk("n2_idle", 32'(valid2), 32'd0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
